axi_arbiter: RTL and testbench

- Shares one AXI4-Lite master port between two requesters: s0 (instruction fetch) and s1 (data memory unit).
- Read and write channels are arbitrated independently, each by its own grant FSM.
- One outstanding transaction per channel.
- Sits between the core's fetch/memory stages and the system interconnect.

---
 rtl/axi_arbiter_pkg.sv | 25 ++
 rtl/axi_arbiter_if.sv | 40 ++++
 rtl/axi_arbiter_rr_pick.sv | 13 +
 rtl/axi_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arbiter_pkg.sv
// Shared types for the two-requester AXI4-Lite arbiter.
package axi_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // 0 = s0 (fetch), 1 = s1 (data)
  typedef logic grant_t;

  // Two-way pick: a lone requester always wins; on a tie round-robin
  // favours whoever was not served last, fixed mode favours s1.
  function automatic grant_t pick2(input logic [1:0] req, input grant_t last,
                                   input logic rr_en);
    if (req == 2'b11) return rr_en ? ~last : 1'b1;
    return req[1];
  endfunction

endpackage

// File: rtl/axi_arbiter_if.sv
// AXI4-Lite bundle used on both requester and downstream sides.
interface axi #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]                  awaddr;
  logic [axi_arbiter_pkg::PROT_W-1:0]     awprot;
  logic                                   awvalid;
  logic                                   awready;
  logic [axi_arbiter_pkg::DATA_W-1:0]     wdata;
  logic [axi_arbiter_pkg::STRB_W-1:0]     wstrb;
  logic                                   wvalid;
  logic                                   wready;
  logic [1:0]                             bresp;
  logic                                   bvalid;
  logic                                   bready;
  logic [ADDR_WIDTH-1:0]                  araddr;
  logic [axi_arbiter_pkg::PROT_W-1:0]     arprot;
  logic                                   arvalid;
  logic                                   arready;
  logic [axi_arbiter_pkg::DATA_W-1:0]     rdata;
  logic [1:0]                             rresp;
  logic                                   rvalid;
  logic                                   rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_arbiter_rr_pick.sv
// Combinational 2-requester picker, one per channel.
module rr_pick
  import axi_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last,
  input  logic       rr_en,
  output grant_t     grant
);

  assign grant = pick2(req, last, rr_en);

endmodule

// File: rtl/axi_arbiter.sv
// Shares one AXI4-Lite master port between fetch (s0) and data (s1).
// Read and write channels each own a grant FSM; grant is registered in
// IDLE so the downstream side sees the request one cycle later.
module axi_arbiter
  import axi_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic clk,
  input  logic resetn,
  axi.slave    s0,
  axi.slave    s1,
  axi.master   m,
  output logic rbusy,
  output logic wbusy
);

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  // ---------------- read channel ----------------
  arb_state_t            rstate;
  grant_t                rgnt, rlast, rpick;
  logic [1:0]            rreq;
  logic                  r_addr, r_resp, ar_fire, r_fire;
  logic [ADDR_WIDTH-1:0] ar_addr_sel;

  assign rreq   = {s1.arvalid, s0.arvalid};
  assign r_addr = (rstate == ADDR);
  assign r_resp = (rstate == RESP);

  rr_pick u_rpick (.req(rreq), .last(rlast), .rr_en(RR_EN), .grant(rpick));

  // read grant FSM; pointer reset to "s1 served last" so s0 wins first tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate <= IDLE;
      rgnt   <= 1'b0;
      rlast  <= 1'b1;
    end else begin
      case (rstate)
        IDLE: if (|rreq) begin
          rgnt   <= rpick;
          rstate <= ADDR;
        end
        ADDR: if (ar_fire) rstate <= RESP;
        RESP: if (r_fire) begin
          rstate <= IDLE;
          rlast  <= rgnt;
        end
        default: rstate <= IDLE;
      endcase
    end
  end

  assign ar_addr_sel = rgnt ? s1.araddr : s0.araddr;
  assign m.araddr    = ar_addr_sel;
  assign m.arprot    = rgnt ? s1.arprot : s0.arprot;
  assign m.arvalid   = r_addr & (rgnt ? s1.arvalid : s0.arvalid);
  assign s0.arready  = r_addr & ~rgnt & m.arready;
  assign s1.arready  = r_addr &  rgnt & m.arready;
  assign ar_fire     = m.arvalid & m.arready;

  assign m.rready    = r_resp & (rgnt ? s1.rready : s0.rready);
  assign s0.rvalid   = r_resp & ~rgnt & m.rvalid;
  assign s1.rvalid   = r_resp &  rgnt & m.rvalid;
  assign s0.rdata    = m.rdata;
  assign s1.rdata    = m.rdata;
  assign s0.rresp    = m.rresp;
  assign s1.rresp    = m.rresp;
  assign r_fire      = m.rvalid & m.rready;

  assign rbusy = (rstate != IDLE);

  // ---------------- write channel ----------------
  arb_state_t            wstate;
  grant_t                wgnt, wlast, wpick;
  logic [1:0]            wreq;
  logic                  w_addr, w_resp, aw_fire, w_fire, b_fire;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] aw_addr_sel;

  assign wreq   = {s1.awvalid | s1.wvalid, s0.awvalid | s0.wvalid};
  assign w_addr = (wstate == ADDR);
  assign w_resp = (wstate == RESP);

  rr_pick u_wpick (.req(wreq), .last(wlast), .rr_en(RR_EN), .grant(wpick));

  // write grant FSM; aw and w complete independently via sticky done flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate  <= IDLE;
      wgnt    <= 1'b0;
      wlast   <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        IDLE: if (|wreq) begin
          wgnt   <= wpick;
          wstate <= ADDR;
        end
        ADDR: begin
          if ((aw_done | aw_fire) & (w_done | w_fire)) begin
            wstate  <= RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
          end
        end
        RESP: if (b_fire) begin
          wstate <= IDLE;
          wlast  <= wgnt;
        end
        default: wstate <= IDLE;
      endcase
    end
  end

  assign aw_addr_sel = wgnt ? s1.awaddr : s0.awaddr;
  assign m.awaddr    = aw_addr_sel;
  assign m.awprot    = wgnt ? s1.awprot : s0.awprot;
  assign m.awvalid   = w_addr & ~aw_done & (wgnt ? s1.awvalid : s0.awvalid);
  assign s0.awready  = w_addr & ~aw_done & ~wgnt & m.awready;
  assign s1.awready  = w_addr & ~aw_done &  wgnt & m.awready;
  assign aw_fire     = m.awvalid & m.awready;

  assign m.wdata     = wgnt ? s1.wdata : s0.wdata;
  assign m.wstrb     = wgnt ? s1.wstrb : s0.wstrb;
  assign m.wvalid    = w_addr & ~w_done & (wgnt ? s1.wvalid : s0.wvalid);
  assign s0.wready   = w_addr & ~w_done & ~wgnt & m.wready;
  assign s1.wready   = w_addr & ~w_done &  wgnt & m.wready;
  assign w_fire      = m.wvalid & m.wready;

  assign m.bready    = w_resp & (wgnt ? s1.bready : s0.bready);
  assign s0.bvalid   = w_resp & ~wgnt & m.bvalid;
  assign s1.bvalid   = w_resp &  wgnt & m.bvalid;
  assign s0.bresp    = m.bresp;
  assign s1.bresp    = m.bresp;
  assign b_fire      = m.bvalid & m.bready;

  assign wbusy = (wstate != IDLE);

endmodule

// File: tb/tb_axi_arbiter.sv
// Scoreboard bench for axi_arbiter: requester drivers, a reactive
// downstream slave model, and a second instance in fixed-priority mode.
module tb_axi_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   nchk = 0, nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi #(.ADDR_WIDTH(32)) s0_if ();
  axi #(.ADDR_WIDTH(32)) s1_if ();
  axi #(.ADDR_WIDTH(32)) m_if ();
  axi #(.ADDR_WIDTH(32)) f0_if ();
  axi #(.ADDR_WIDTH(32)) f1_if ();
  axi #(.ADDR_WIDTH(32)) fm_if ();
  logic rbusy, wbusy, f_rbusy, f_wbusy;

  axi_arbiter #(.ROUND_ROBIN(1), .ADDR_WIDTH(32)) u_dut (
    .clk(clk), .resetn(resetn), .s0(s0_if), .s1(s1_if), .m(m_if),
    .rbusy(rbusy), .wbusy(wbusy));

  axi_arbiter #(.ROUND_ROBIN(0), .ADDR_WIDTH(32)) u_fix (
    .clk(clk), .resetn(resetn), .s0(f0_if), .s1(f1_if), .m(fm_if),
    .rbusy(f_rbusy), .wbusy(f_wbusy));

  // requester-side drive
  logic [1:0]  arv = '0, awv = '0, wv = '0;
  logic [31:0] ara [2];
  logic [31:0] awa [2];
  logic [31:0] wd  [2];
  logic [3:0]  ws  [2];

  assign s0_if.arvalid = arv[0];  assign s1_if.arvalid = arv[1];
  assign s0_if.araddr  = ara[0];  assign s1_if.araddr  = ara[1];
  assign s0_if.arprot  = 3'b100;  assign s1_if.arprot  = 3'b000;
  assign s0_if.awvalid = awv[0];  assign s1_if.awvalid = awv[1];
  assign s0_if.awaddr  = awa[0];  assign s1_if.awaddr  = awa[1];
  assign s0_if.awprot  = 3'b100;  assign s1_if.awprot  = 3'b000;
  assign s0_if.wvalid  = wv[0];   assign s1_if.wvalid  = wv[1];
  assign s0_if.wdata   = wd[0];   assign s1_if.wdata   = wd[1];
  assign s0_if.wstrb   = ws[0];   assign s1_if.wstrb   = ws[1];
  assign s0_if.rready  = 1'b1;    assign s1_if.rready  = 1'b1;
  assign s0_if.bready  = 1'b1;    assign s1_if.bready  = 1'b1;

  wire [1:0] s_arready = {s1_if.arready, s0_if.arready};
  wire [1:0] s_awready = {s1_if.awready, s0_if.awready};
  wire [1:0] s_wready  = {s1_if.wready,  s0_if.wready};
  wire [1:0] s_rvalid  = {s1_if.rvalid,  s0_if.rvalid};
  wire [1:0] s_bvalid  = {s1_if.bvalid,  s0_if.bvalid};

  // fixed-priority instance: both requesters keep asking, downstream always ready
  logic fixv = 1'b0;
  assign f0_if.arvalid = fixv;   assign f1_if.arvalid = fixv;
  assign f0_if.araddr  = 32'h0;  assign f1_if.araddr  = 32'h4;
  assign f0_if.arprot  = 3'b100; assign f1_if.arprot  = 3'b000;
  assign f0_if.rready  = 1'b1;   assign f1_if.rready  = 1'b1;
  assign f0_if.awvalid = 1'b0;   assign f1_if.awvalid = 1'b0;
  assign f0_if.awaddr  = 32'h0;  assign f1_if.awaddr  = 32'h0;
  assign f0_if.awprot  = 3'b0;   assign f1_if.awprot  = 3'b0;
  assign f0_if.wvalid  = 1'b0;   assign f1_if.wvalid  = 1'b0;
  assign f0_if.wdata   = 32'h0;  assign f1_if.wdata   = 32'h0;
  assign f0_if.wstrb   = 4'h0;   assign f1_if.wstrb   = 4'h0;
  assign f0_if.bready  = 1'b1;   assign f1_if.bready  = 1'b1;
  assign fm_if.arready = 1'b1;   assign fm_if.rvalid  = 1'b1;
  assign fm_if.rdata   = 32'hCAFE0000; assign fm_if.rresp = 2'b00;
  assign fm_if.awready = 1'b0;   assign fm_if.wready  = 1'b0;
  assign fm_if.bvalid  = 1'b0;   assign fm_if.bresp   = 2'b00;

  // scoreboard queues
  logic [34:0] q_mar [$];   // {prot, addr} expected on m.ar, in service order
  logic [67:0] q_mw  [$];   // {addr, data, strb} expected on m.aw/w
  logic [33:0] q_r0 [$], q_r1 [$];
  logic [1:0]  q_b0 [$], q_b1 [$];
  int ar_cyc_q [$];
  int aw_cyc = -1, w_cyc = -1;
  int b_cyc [2];
  bit both_seen = 1'b0;

  int ar_hold = 0, aw_hold = 0, w_hold = 0, r_stall = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[12] ? 2'b10 : 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_ar(input int who, input logic [31:0] a);
    q_mar.push_back({(who == 0) ? 3'b100 : 3'b000, a});
  endtask

  task automatic rd(input int who, input logic [31:0] a);
    bit hit;
    int n;
    if (who == 0) q_r0.push_back({resp_of(a), mem_rd(a)});
    else          q_r1.push_back({resp_of(a), mem_rd(a)});
    ara[who] = a;
    arv[who] = 1'b1;
    n = 0;
    while (arv[who]) begin
      @(negedge clk);
      hit = s_arready[who];
      tick();
      n++;
      if (hit) arv[who] = 1'b0;
      else if (n > 60) begin
        chk("rd_ar_timeout", 0, 1);
        arv[who] = 1'b0;
      end
    end
  endtask

  task automatic wr(input int who, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    bit ah, wh;
    int n;
    q_mw.push_back({a, d, s});
    if (who == 0) q_b0.push_back(resp_of(a));
    else          q_b1.push_back(resp_of(a));
    awa[who] = a; wd[who] = d; ws[who] = s;
    awv[who] = 1'b1; wv[who] = 1'b1;
    n = 0;
    while (awv[who] | wv[who]) begin
      @(negedge clk);
      ah = awv[who] & s_awready[who];
      wh = wv[who] & s_wready[who];
      tick();
      n++;
      if (ah) awv[who] = 1'b0;
      if (wh) wv[who] = 1'b0;
      if (n > 60) begin
        chk("wr_timeout", 0, 1);
        awv[who] = 1'b0; wv[who] = 1'b0;
      end
    end
  endtask

  // wait for all expected traffic to retire and both channels to idle
  task automatic drain();
    int n;
    n = 0;
    while ((q_mar.size() + q_mw.size() + q_r0.size() + q_r1.size() +
            q_b0.size() + q_b1.size()) != 0 || rbusy || wbusy) begin
      tick();
      n++;
      if (n > 100) begin
        chk("drain_timeout", 0, 1);
        q_mar.delete(); q_mw.delete(); q_r0.delete(); q_r1.delete();
        q_b0.delete(); q_b1.delete();
        break;
      end
    end
    tick();
  endtask

  // monitor: m.ar order/content, requester responses, event timestamps
  initial begin
    logic [34:0] e35;
    logic [33:0] e34;
    logic [1:0]  e2;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (m_if.arvalid & m_if.arready) begin
          ar_cyc_q.push_back(cyc);
          if (q_mar.size() == 0) chk("m_ar_unexpected", {m_if.arprot, m_if.araddr}, 0);
          else begin
            e35 = q_mar.pop_front();
            chk("m_ar", {m_if.arprot, m_if.araddr}, e35);
          end
        end
        if (m_if.arvalid & m_if.awvalid) both_seen = 1'b1;
        if (m_if.awvalid & m_if.awready) aw_cyc = cyc;
        if (m_if.wvalid & m_if.wready)   w_cyc  = cyc;
        if (s_rvalid[0]) begin
          if (q_r0.size() == 0) chk("s0_r_unexpected", {s0_if.rresp, s0_if.rdata}, 0);
          else begin e34 = q_r0.pop_front(); chk("s0_r", {s0_if.rresp, s0_if.rdata}, e34); end
        end
        if (s_rvalid[1]) begin
          if (q_r1.size() == 0) chk("s1_r_unexpected", {s1_if.rresp, s1_if.rdata}, 0);
          else begin e34 = q_r1.pop_front(); chk("s1_r", {s1_if.rresp, s1_if.rdata}, e34); end
        end
        if (s_bvalid[0]) begin
          b_cyc[0] = cyc;
          if (q_b0.size() == 0) chk("s0_b_unexpected", s0_if.bresp, 3);
          else begin e2 = q_b0.pop_front(); chk("s0_b", s0_if.bresp, e2); end
        end
        if (s_bvalid[1]) begin
          b_cyc[1] = cyc;
          if (q_b1.size() == 0) chk("s1_b_unexpected", s1_if.bresp, 3);
          else begin e2 = q_b1.pop_front(); chk("s1_b", s1_if.bresp, e2); end
        end
      end
    end
  end

  // downstream slave model: sample handshakes at negedge, update after posedge
  initial begin
    logic arf, rf, awf, wf, bf, arv_s, awv_s, wv_s;
    logic [31:0] c_ara, c_awa, c_wd;
    logic [3:0]  c_ws;
    logic        r_pend, aw_got, w_got;
    logic [31:0] rd_a, wr_a, wr_d;
    logic [3:0]  wr_s;
    logic [67:0] e68;
    int          r_cnt;
    r_pend = 0; aw_got = 0; w_got = 0; r_cnt = 0;
    rd_a = 0; wr_a = 0; wr_d = 0; wr_s = 0;
    m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
    m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
    m_if.bvalid = 1'b0; m_if.bresp = '0;
    forever begin
      @(negedge clk);
      arf = m_if.arvalid & m_if.arready;  rf = m_if.rvalid & m_if.rready;
      awf = m_if.awvalid & m_if.awready;  wf = m_if.wvalid & m_if.wready;
      bf  = m_if.bvalid & m_if.bready;
      arv_s = m_if.arvalid; awv_s = m_if.awvalid; wv_s = m_if.wvalid;
      c_ara = m_if.araddr; c_awa = m_if.awaddr; c_wd = m_if.wdata; c_ws = m_if.wstrb;
      tick();
      if (!resetn) begin
        r_pend = 0; aw_got = 0; w_got = 0;
        m_if.rvalid = 1'b0; m_if.bvalid = 1'b0;
        continue;
      end
      if (arv_s && ar_hold > 0) ar_hold--;
      if (awv_s && aw_hold > 0) aw_hold--;
      if (wv_s && w_hold > 0)   w_hold--;
      m_if.arready = (ar_hold == 0);
      m_if.awready = (aw_hold == 0);
      m_if.wready  = (w_hold == 0);
      if (rf) begin m_if.rvalid = 1'b0; r_pend = 0; end
      if (arf) begin rd_a = c_ara; r_pend = 1; r_cnt = r_stall; end
      if (r_pend && !m_if.rvalid) begin
        if (r_cnt == 0) begin
          m_if.rvalid = 1'b1; m_if.rdata = mem_rd(rd_a); m_if.rresp = resp_of(rd_a);
        end else r_cnt--;
      end
      if (bf) m_if.bvalid = 1'b0;
      if (awf) begin wr_a = c_awa; aw_got = 1; end
      if (wf)  begin wr_d = c_wd; wr_s = c_ws; w_got = 1; end
      if (aw_got && w_got && !m_if.bvalid) begin
        if (q_mw.size() == 0) chk("m_w_unexpected", {wr_a, wr_d, wr_s}, 0);
        else begin e68 = q_mw.pop_front(); chk("m_w", {wr_a, wr_d, wr_s}, e68); end
        m_if.bvalid = 1'b1; m_if.bresp = resp_of(wr_a);
        aw_got = 0; w_got = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    nfail++;
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    int n0, n1, r0c, rb, nb;
    for (int i = 0; i < 2; i++) begin
      ara[i] = '0; awa[i] = '0; wd[i] = '0; ws[i] = '0; b_cyc[i] = -1;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_out", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 0);
    chk("rst_s_out", {s_arready, s_awready, s_wready, s_rvalid, s_bvalid}, 0);
    chk("rst_busy", {rbusy, wbusy}, 0);
    tick();
    resetn = 1'b1;
    tick();

    // tie, pointer fresh from reset: s0 then s1, one idle cycle between
    exp_ar(0, 32'h010); exp_ar(1, 32'h020);
    fork rd(0, 32'h010); rd(1, 32'h020); join
    drain();
    chk("rr_gap_a", ar_cyc_q[$] - ar_cyc_q[$-1], 3);

    // tie again after s1 was served last: s0 wins again
    exp_ar(0, 32'h030); exp_ar(1, 32'h040);
    fork rd(0, 32'h030); rd(1, 32'h040); join
    drain();
    chk("rr_gap_b", ar_cyc_q[$] - ar_cyc_q[$-1], 3);

    // single s0 read: m.arvalid one cycle after request, rbusy for 2 cycles
    exp_ar(0, 32'h100);
    fork rd(0, 32'h100); join_none
    @(negedge clk);
    chk("lat_c0_arvalid", m_if.arvalid, 0);
    @(negedge clk);
    chk("lat_c1_arvalid", m_if.arvalid, 1);
    rb = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rbusy) rb++;
    end
    chk("rbusy_cycles", rb, 2);
    drain();

    // s1 write with awready held 3 cycles: w completes first
    aw_hold = 3; w_hold = 0;
    tick();
    aw_cyc = -1; w_cyc = -1; b_cyc[1] = -1;
    fork wr(1, 32'h200, 32'h12345678, 4'b0011); join_none
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("w_s0_bvalid", s_bvalid[0], 0);
      if (w_cyc >= 0 && cyc > w_cyc && m_if.awvalid) chk("wvalid_drop", m_if.wvalid, 0);
    end
    drain();
    chk("w_before_aw", aw_cyc - w_cyc, 3);
    chk("b_after_aw", b_cyc[1] - aw_cyc, 1);

    // concurrent s0 read and s1 write (SLVERR address)
    both_seen = 1'b0;
    exp_ar(0, 32'h340);
    fork rd(0, 32'h340); wr(1, 32'h1300, 32'hA5A50F0F, 4'b1111); join
    drain();
    chk("concurrent_ar_aw", both_seen, 1);
    chk("concurrent_cyc", ar_cyc_q[$] - aw_cyc, 0);

    // rvalid stalled 5 cycles while s1 read waits
    r_stall = 5;
    exp_ar(0, 32'h480); exp_ar(1, 32'h1490);
    fork rd(0, 32'h480); join_none
    tick(); tick();
    fork rd(1, 32'h1490); join_none
    r0c = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_rvalid[0]) begin r0c = cyc; break; end
      chk("stall_s1_arready", s_arready[1], 0);
    end
    chk("stall_r0_seen", r0c >= 0, 1);
    drain();
    r_stall = 0;
    chk("s1_grant_lat", ar_cyc_q[$] - r0c, 2);

    // async reset in the middle of a read response
    r_stall = 8;
    exp_ar(0, 32'h500);
    ara[0] = 32'h500; arv[0] = 1'b1;
    nb = 0;
    while (arv[0]) begin
      @(negedge clk);
      n0 = s_arready[0];
      tick();
      nb++;
      if (n0 != 0 || nb > 20) arv[0] = 1'b0;
    end
    tick(); tick();
    chk("rst_pre_rbusy", rbusy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_m", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.rready, m_if.bready}, 0);
    chk("rst_mid_busy", {rbusy, wbusy}, 0);
    q_mar.delete();
    tick(); tick();
    resetn = 1'b1;
    r_stall = 0;
    tick();
    exp_ar(1, 32'h600);
    rd(1, 32'h600);
    drain();

    // fixed priority: s1 wins every round while both keep requesting
    fixv = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f0_if.arready) n0++;
      if (f1_if.arready) n1++;
    end
    fixv = 1'b0;
    chk("fixed_s0_grants", n0, 0);
    chk("fixed_s1_grants", n1, 4);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
